split_assign_loader: RTL and testbench
======================================

SPLIT_ASSIGN_LOADER -- requirements
Module: split_assign_loader

Interface
REQ-001 Parameter NUM_VARS, default 50, number of split variables per candidate.
REQ-002 Parameter DATA_W, default 16, write-word width (widest variable).
REQ-003 Parameter CNT_W, default 16, width of tally counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wr_valid  input  1  write word present.
REQ-007 wr_ready  output  1  loader accepts a write word.
REQ-008 wr_idx  input  6  variable index of word, 0..NUM_VARS-1.
REQ-009 wr_data  input  DATA_W  variable value, LSB-aligned.
REQ-010 flush  input  1  discard partial candidate.
REQ-011 cand_flat  output  516  packed candidate; var_k at VAR_OFS[k] with width VAR_W[k], var_0 at bit 0.
REQ-012 cand_valid  output  1  cand_flat complete and stable for the split stage.
REQ-013 sat_in  input  1  split verdict x, combinational from cand_flat.
REQ-014 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-015 res_sat, res_err  output  1, 1  verdict; protocol error flag.
REQ-016 res_total, res_sat_cnt  output  CNT_W each  candidates reported; satisfied candidates.

Function
REQ-017 States LOAD, EVAL, REPORT; rst enters LOAD.
REQ-018 LOAD: wr_ready=1; word accepted when wr_valid&&wr_ready; stored truncated to VAR_W[wr_idx].
REQ-019 Expected index counter starts at 0, increments per accepted word; word with wr_idx != expected sets sticky err, still stored at wr_idx if <NUM_VARS, else dropped.
REQ-020 Any nonzero wr_data bit at or above VAR_W[wr_idx] sets sticky err.
REQ-021 Accepting the word with expected index NUM_VARS-1 moves LOAD->EVAL next cycle.
REQ-022 EVAL lasts exactly one cycle: cand_valid=1, wr_ready=0, sat_in registered into res_sat; then ->REPORT.
REQ-023 REPORT: res_valid=1, cand_valid=0, wr_ready=0; res_sat, res_err, counters held stable until res_ready.
REQ-024 On res_valid&&res_ready: ->LOAD, expected index=0, err cleared, cand_flat retained.
REQ-025 res_total increments and res_sat_cnt increments iff res_sat&&!res_err, both on the EVAL->REPORT edge; both saturate at 2^CNT_W-1.
REQ-026 flush in LOAD: expected index=0, err cleared, accepted word that cycle ignored; flush ignored in EVAL/REPORT.
REQ-027 Latency: last accepted word to res_valid = 2 cycles.

Reset
REQ-028 rst: state LOAD, wr_ready=1 from next cycle, cand_flat=0, cand_valid=0, res_valid=0, res_sat=0, res_err=0, counters=0.
REQ-029 rst asserted mid-load or in REPORT discards candidate and pending result, no counter update.

Structure
REQ-030 Package split_pkg holds NUM_VARS, CAND_W=516, VAR_W[] and VAR_OFS[] constant arrays.
REQ-031 One sub-module split_sat_counter (saturating CNT_W counter, inc/clear) instantiated twice.

Verification
REQ-032 Write idx 0..49 in order, all values max-width, sat_in=1 -> res_valid 2 cycles after last word, res_sat=1, res_err=0, res_total=1, res_sat_cnt=1.
REQ-033 Write var_1 (4 bits) with data 0x001F -> stored 0xF, res_err=1, res_sat_cnt unchanged.
REQ-034 Skip idx 7 (send 8 after 6) -> res_err=1; load still needs idx 49 in-sequence to complete.
REQ-035 Hold res_ready=0 for 10 cycles -> outputs stable, wr_ready=0, wr_valid words not accepted.
REQ-036 flush after idx 20, reload 0..49 -> single report, res_err=0; rst at idx 30 -> counters 0, cand_flat=0.
REQ-037 Preload counters to 0xFFFF via 65535 sat candidates (or force) -> next sat candidate keeps 0xFFFF.

Source files
------------

// File: rtl/split_pkg.sv
// Shared constants for the split-assignment loader: candidate layout and FSM states.
package split_pkg;

  localparam int NUM_VARS = 50;
  localparam int CAND_W   = 516;

  // Widths repeat 16,4,8,12,12; the final variable is 8 bits wide so the total is 516.
  localparam int VAR_W [NUM_VARS] = '{
    16, 4, 8, 12, 12,  16, 4, 8, 12, 12,  16, 4, 8, 12, 12,  16, 4, 8, 12, 12,
    16, 4, 8, 12, 12,  16, 4, 8, 12, 12,  16, 4, 8, 12, 12,  16, 4, 8, 12, 12,
    16, 4, 8, 12, 12,  16, 4, 8, 12,  8
  };

  localparam int VAR_OFS [NUM_VARS] = '{
      0,  16,  20,  28,  40,   52,  68,  72,  80,  92,
    104, 120, 124, 132, 144,  156, 172, 176, 184, 196,
    208, 224, 228, 236, 248,  260, 276, 280, 288, 300,
    312, 328, 332, 340, 352,  364, 380, 384, 392, 404,
    416, 432, 436, 444, 456,  468, 484, 488, 496, 508
  };

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/split_sat_counter.sv
// Saturating up-counter with synchronous clear.
module split_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) cnt_q <= cnt_d;

  assign cnt_o = cnt_q;

endmodule

// File: rtl/split_assign_loader.sv
// Loads one candidate assignment word-by-word, presents it to the split stage for
// one cycle, then reports the verdict with running tallies.
module split_assign_loader
  import split_pkg::*;
#(
  parameter int NUM_VARS = split_pkg::NUM_VARS,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [5:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic [CAND_W-1:0] cand_flat,
  output logic              cand_valid,
  input  logic              sat_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_sat,
  output logic              res_err,
  output logic [CNT_W-1:0]  res_total,
  output logic [CNT_W-1:0]  res_sat_cnt
);

  state_e        st_q, st_d;
  logic [5:0]    exp_q, exp_d;
  logic          err_q, err_d;
  logic          sat_q, sat_d;
  logic          acc, last, over_hit, inc_tot, inc_sat;
  logic [NUM_VARS-1:0] hit, over;

  // A flushed cycle never stores its word.
  assign acc      = wr_valid && (st_q == ST_LOAD) && !flush;
  assign wr_ready = (st_q == ST_LOAD);

  for (genvar k = 0; k < NUM_VARS; k++) begin : g_var
    logic [VAR_W[k]-1:0] v_q;

    assign hit[k]  = acc && (wr_idx == 6'(k));
    assign over[k] = (wr_data >> VAR_W[k]) != '0;

    always_ff @(posedge clk) begin
      if (rst)         v_q <= '0;
      else if (hit[k]) v_q <= wr_data[VAR_W[k]-1:0];
    end

    assign cand_flat[VAR_OFS[k] +: VAR_W[k]] = v_q;
  end

  assign over_hit = |(hit & over);
  // Completion needs the final index to arrive exactly when it is expected.
  assign last = acc && (wr_idx == exp_q) && (exp_q == 6'(NUM_VARS-1));

  always_comb begin
    st_d       = st_q;
    exp_d      = exp_q;
    err_d      = err_q;
    sat_d      = sat_q;
    cand_valid = 1'b0;
    res_valid  = 1'b0;
    inc_tot    = 1'b0;
    inc_sat    = 1'b0;
    case (st_q)
      ST_LOAD: begin
        if (flush) begin
          exp_d = '0;
          err_d = 1'b0;
        end else if (wr_valid) begin
          exp_d = exp_q + 6'd1;
          if ((wr_idx != exp_q) || over_hit) err_d = 1'b1;
          if (last) st_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        cand_valid = 1'b1;
        sat_d      = sat_in;
        inc_tot    = 1'b1;
        inc_sat    = sat_in && !err_q;
        st_d       = ST_REPORT;
      end
      ST_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          st_d  = ST_LOAD;
          exp_d = '0;
          err_d = 1'b0;
        end
      end
      default: st_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_LOAD;
      exp_q <= '0;
      err_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      exp_q <= exp_d;
      err_q <= err_d;
      sat_q <= sat_d;
    end
  end

  assign res_sat = sat_q;
  assign res_err = err_q;

  split_sat_counter #(.CNT_W(CNT_W)) u_total (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (inc_tot),
    .cnt_o (res_total)
  );

  split_sat_counter #(.CNT_W(CNT_W)) u_sat (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (inc_sat),
    .cnt_o (res_sat_cnt)
  );

endmodule

// File: tb/tb_split_assign_loader.sv
// Randomized scoreboard bench for split_assign_loader with a word-level reference model.
module tb_split_assign_loader;
  import split_pkg::*;

  localparam int NV   = 50;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, wr_valid, wr_ready, flush, cand_valid, sat_in;
  logic res_valid, res_ready, res_sat, res_err;
  logic [5:0]        wr_idx;
  logic [15:0]       wr_data;
  logic [CAND_W-1:0] cand_flat;
  logic [CW-1:0]     res_total, res_sat_cnt;

  split_assign_loader #(.NUM_VARS(NV), .DATA_W(16), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_data(wr_data), .flush(flush), .cand_flat(cand_flat), .cand_valid(cand_valid),
    .sat_in(sat_in), .res_valid(res_valid), .res_ready(res_ready), .res_sat(res_sat),
    .res_err(res_err), .res_total(res_total), .res_sat_cnt(res_sat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  bit sat_force, sat_val;
  assign sat_in = sat_force ? sat_val : ^cand_flat;

  typedef struct {
    bit                sat;
    bit                err;
    int                tot;
    int                satc;
    logic [CAND_W-1:0] cand;
    int                due;
  } exp_t;
  exp_t q[$];

  logic [15:0] m_var [NV];
  int m_exp, m_tot, m_satc;
  bit m_err;

  task automatic chk(input string name, input logic [CAND_W-1:0] act, input logic [CAND_W-1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [CAND_W-1:0] model_cand();
    logic [CAND_W-1:0] c = '0;
    for (int k = 0; k < NV; k++)
      for (int b = 0; b < VAR_W[k]; b++) c[VAR_OFS[k] + b] = m_var[k][b];
    return c;
  endfunction

  function automatic bit model_parity();
    bit p = 1'b0;
    for (int k = 0; k < NV; k++) p ^= ^m_var[k];
    return p;
  endfunction

  function automatic logic [15:0] legal_data(input int idx);
    logic [15:0] d = 16'($urandom);
    if (idx < NV) d = d & 16'((1 << VAR_W[idx]) - 1);
    return d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NV; k++) m_var[k] = '0;
    m_exp = 0; m_err = 1'b0; m_tot = 0; m_satc = 0;
  endtask

  task automatic send(input int idx, input logic [15:0] d, output bit done);
    int   drv;
    exp_t e;
    chk("wr_ready_load", wr_ready, 1);
    wr_valid = 1'b1; wr_idx = 6'(idx); wr_data = d; drv = cyc;
    done = (idx == m_exp) && (m_exp == NV - 1);
    if (idx != m_exp) m_err = 1'b1;
    if (idx < NV) begin
      if ((d >> VAR_W[idx]) != 0) m_err = 1'b1;
      m_var[idx] = d & 16'((1 << VAR_W[idx]) - 1);
    end
    m_exp++;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    if (done) begin
      e.sat = sat_force ? sat_val : model_parity();
      e.err = m_err;
      if (m_tot < CMAX) m_tot++;
      if (e.sat && !m_err && m_satc < CMAX) m_satc++;
      e.tot = m_tot; e.satc = m_satc; e.cand = model_cand(); e.due = drv + 2;
      q.push_back(e);
      m_exp = 0; m_err = 1'b0;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1; wr_valid = 1'($urandom); wr_idx = 6'($urandom); wr_data = 16'($urandom);
    @(posedge clk); #1;
    flush = 1'b0; wr_valid = 1'b0;
    m_exp = 0; m_err = 1'b0;
  endtask

  // Offered words during the hold must be ignored; the monitor checks stability.
  task automatic wait_report(input int hold);
    int t = 0;
    res_ready = 1'b0;
    while (!res_valid && t < 10) begin @(posedge clk); #1; t++; end
    if (!res_valid) begin fail_now("res_valid_timeout"); return; end
    repeat (hold) begin
      wr_valid = 1'b1; wr_idx = 6'($urandom); wr_data = 16'($urandom);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_cand"}, cand_flat, '0);
    chk({tag, "_total"}, res_total, '0);
    chk({tag, "_satcnt"}, res_sat_cnt, '0);
    chk({tag, "_flags"}, {wr_ready, cand_valid, res_valid, res_sat, res_err}, 5'b10000);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; wr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    model_reset();
  endtask

  bit in_rep = 1'b0;
  always @(negedge clk) begin
    if (cand_valid) begin
      if (q.size() == 0) fail_now("cand_valid_unexpected");
      else begin
        chk("eval_cand", cand_flat, q[0].cand);
        chk("eval_wr_ready", wr_ready, 0);
      end
    end
    if (res_valid) begin
      if (q.size() == 0) fail_now("res_valid_unexpected");
      else begin
        if (!in_rep) chk("latency", cyc, q[0].due);
        chk("res_sat", res_sat, q[0].sat);
        chk("res_err", res_err, q[0].err);
        chk("res_total", res_total, q[0].tot);
        chk("res_sat_cnt", res_sat_cnt, q[0].satc);
        chk("rep_cand", cand_flat, q[0].cand);
        chk("rep_flags", {wr_ready, cand_valid}, 2'b00);
        if (res_ready) void'(q.pop_front());
      end
    end
    in_rep = res_valid && !res_ready;
  end

  initial begin
    bit done;
    int guard, r, idx;
    rst = 1'b1; wr_valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
    wr_idx = '0; wr_data = '0; sat_force = 1'b1; sat_val = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    reset_checks("por");

    // All variables at full width, verdict forced true.
    for (int k = 0; k < NV; k++) send(k, 16'((1 << VAR_W[k]) - 1), done);
    wait_report(2);

    // Over-wide data on the 4-bit var_1.
    for (int k = 0; k < NV; k++) send(k, (k == 1) ? 16'h001F : legal_data(k), done);
    wait_report(0);

    // Skip index 7; completion needs an in-sequence 49 afterwards.
    for (int k = 0; k < NV; k++) if (k != 7) send(k, legal_data(k), done);
    chk("skip_not_done", done, 0);
    send(NV - 1, legal_data(NV - 1), done);
    chk("skip_done", done, 1);
    wait_report(0);

    // Long back-pressure on the result.
    sat_force = 1'b0;
    for (int k = 0; k < NV; k++) send(k, legal_data(k), done);
    wait_report(10);

    // Flush mid-load, then a clean reload.
    for (int k = 0; k <= 20; k++) send(k, 16'($urandom), done);
    do_flush();
    for (int k = 0; k < NV; k++) send(k, legal_data(k), done);
    wait_report(1);

    // Reset mid-load.
    for (int k = 0; k <= 30; k++) send(k, legal_data(k), done);
    pulse_reset();
    reset_checks("rst_load");

    // Reset while a result is pending.
    for (int k = 0; k < NV; k++) send(k, legal_data(k), done);
    guard = 0;
    while (!res_valid && guard < 10) begin @(posedge clk); #1; guard++; end
    if (!res_valid) fail_now("rst_report_wait");
    pulse_reset();
    reset_checks("rst_report");

    // Randomized candidates; enough reports to saturate the narrow counters.
    for (int c = 0; c < 25; c++) begin
      sat_force = 1'($urandom); sat_val = 1'($urandom);
      done = 1'b0; guard = 0;
      while (!done && guard < 400) begin
        guard++;
        r = $urandom_range(0, 99);
        if (m_exp > NV - 1 || r < 2) do_flush();
        else if (r < 8) begin @(posedge clk); #1; end
        else begin
          idx = (r < 12) ? $urandom_range(0, 63) : m_exp;
          send(idx, (r >= 96) ? 16'($urandom) : legal_data(idx), done);
        end
      end
      if (!done) fail_now("random_load");
      else wait_report($urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    chk("total_saturated", res_total, CMAX);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
